// File: rtl/alarm_ring_ctrl.sv
// Alarm buzzer sequencer: detects the alarm minute, then drives a timed beep
// cadence on aud_en with snooze, user-off and auto-timeout handling.
module alarm_ring_ctrl #(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3,
  parameter int BEEP_ON    = 1,
  parameter int BEEP_OFF   = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       tick_sec,
  input  logic       bud_en,
  input  logic       off_bud,
  input  logic       snooze,
  input  logic [3:0] hourdec_now,
  input  logic [3:0] hourone_now,
  input  logic [3:0] mindec_now,
  input  logic [3:0] minone_now,
  input  logic [3:0] hourdec_bud,
  input  logic [3:0] hourone_bud,
  input  logic [3:0] mindec_bud,
  input  logic [3:0] minone_bud,
  output logic       aud_en,
  output logic       ringing,
  output logic       snoozing,
  output logic [2:0] snooze_cnt,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    RING   = 2'd2,
    SNOOZE = 2'd3
  } state_t;

  localparam logic [15:0] RING_LAST   = 16'(RING_SEC - 1);
  localparam logic [15:0] SNOOZE_LAST = 16'(SNOOZE_SEC - 1);
  localparam logic [15:0] BEEP_LAST   = 16'(BEEP_ON + BEEP_OFF - 1);
  localparam logic [15:0] BEEP_ON_W   = 16'(BEEP_ON);
  localparam logic [2:0]  MAX_SNZ     = 3'(MAX_SNOOZE);

  state_t      state, nxt_state;
  logic [15:0] sec_cnt, nxt_sec;
  logic [15:0] beep_cnt, nxt_beep;
  logic [2:0]  nxt_snz;
  logic        match, match_q, match_rise;
  logic        snooze_q, snooze_rise;

  assign match = (hourdec_now == hourdec_bud) && (hourone_now == hourone_bud) &&
                 (mindec_now == mindec_bud) && (minone_now == minone_bud);
  assign match_rise  = match & ~match_q;
  assign snooze_rise = snooze & ~snooze_q;
  assign state_dbg   = state;

  // Control events are tested before tick_sec, so a coincident tick is dropped.
  always_comb begin
    nxt_state = state;
    nxt_sec   = sec_cnt;
    nxt_beep  = beep_cnt;
    nxt_snz   = snooze_cnt;
    if (!bud_en) begin
      nxt_state = IDLE;
    end else begin
      case (state)
        IDLE: nxt_state = ARMED;
        ARMED: begin
          if (match_rise) begin
            nxt_state = RING;
            nxt_sec   = '0;
            nxt_beep  = '0;
            nxt_snz   = '0;
          end
        end
        RING: begin
          if (off_bud) begin
            nxt_state = ARMED;
          end else if (snooze_rise && (snooze_cnt < MAX_SNZ)) begin
            nxt_state = SNOOZE;
            nxt_sec   = '0;
            nxt_snz   = snooze_cnt + 3'd1;
          end else if (tick_sec) begin
            if (sec_cnt == RING_LAST) begin
              nxt_state = ARMED;
            end else begin
              nxt_sec  = sec_cnt + 16'd1;
              nxt_beep = (beep_cnt == BEEP_LAST) ? 16'd0 : beep_cnt + 16'd1;
            end
          end
        end
        SNOOZE: begin
          if (off_bud) begin
            nxt_state = ARMED;
          end else if (tick_sec) begin
            if (sec_cnt == SNOOZE_LAST) begin
              nxt_state = RING;
              nxt_sec   = '0;
              nxt_beep  = '0;
            end else begin
              nxt_sec = sec_cnt + 16'd1;
            end
          end
        end
        default: nxt_state = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next-state values so they line up with state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      sec_cnt    <= '0;
      beep_cnt   <= '0;
      snooze_cnt <= '0;
      match_q    <= 1'b0;
      snooze_q   <= 1'b0;
      aud_en     <= 1'b0;
      ringing    <= 1'b0;
      snoozing   <= 1'b0;
    end else begin
      state      <= nxt_state;
      sec_cnt    <= nxt_sec;
      beep_cnt   <= nxt_beep;
      snooze_cnt <= nxt_snz;
      match_q    <= match;
      snooze_q   <= snooze;
      aud_en     <= (nxt_state == RING) && (nxt_beep < BEEP_ON_W);
      ringing    <= (nxt_state == RING);
      snoozing   <= (nxt_state == SNOOZE);
    end
  end

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Bench for alarm_ring_ctrl: directed scenarios plus random traffic, all
// compared against a behavioural model counting elapsed seconds per phase.
module tb_alarm_ring_ctrl;

  localparam int RING_SEC   = 4;
  localparam int SNOOZE_SEC = 3;
  localparam int MAX_SNOOZE = 2;
  localparam int BEEP_ON    = 1;
  localparam int BEEP_OFF   = 1;

  localparam int M_IDLE = 0, M_ARMED = 1, M_RING = 2, M_SNOOZE = 3;

  logic       clk = 1'b0;
  logic       rstn;
  logic       tick_sec = 1'b0, bud_en = 1'b0, off_bud = 1'b0, snooze = 1'b0;
  logic [3:0] hourdec_now = 4'd0, hourone_now = 4'd0, mindec_now = 4'd0, minone_now = 4'd0;
  logic [3:0] hourdec_bud = 4'd0, hourone_bud = 4'd7, mindec_bud = 4'd3, minone_bud = 4'd0;
  logic       aud_en, ringing, snoozing;
  logic [2:0] snooze_cnt;
  logic [1:0] state_dbg;

  int errors = 0;
  int checks = 0;

  alarm_ring_ctrl #(
    .RING_SEC(RING_SEC), .SNOOZE_SEC(SNOOZE_SEC), .MAX_SNOOZE(MAX_SNOOZE),
    .BEEP_ON(BEEP_ON), .BEEP_OFF(BEEP_OFF)
  ) dut (
    .clk(clk), .rstn(rstn), .tick_sec(tick_sec), .bud_en(bud_en),
    .off_bud(off_bud), .snooze(snooze),
    .hourdec_now(hourdec_now), .hourone_now(hourone_now),
    .mindec_now(mindec_now), .minone_now(minone_now),
    .hourdec_bud(hourdec_bud), .hourone_bud(hourone_bud),
    .mindec_bud(mindec_bud), .minone_bud(minone_bud),
    .aud_en(aud_en), .ringing(ringing), .snoozing(snoozing),
    .snooze_cnt(snooze_cnt), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  // Reference model: tracks the phase, seconds spent in it, and ticks since
  // ringing began; the beep phase is just that tick count mod the cadence.
  int   m_mode, m_secs, m_ring_ticks, m_snz;
  bit   m_prev_match, m_prev_snz;
  logic [7:0] exp_w;
  wire  [7:0] obs_w = {state_dbg, aud_en, ringing, snoozing, snooze_cnt};

  always @(posedge clk or negedge rstn) begin
    bit mt, mr, sr;
    if (!rstn) begin
      m_mode = M_IDLE; m_secs = 0; m_ring_ticks = 0; m_snz = 0;
      m_prev_match = 0; m_prev_snz = 0;
    end else begin
      mt = ({hourdec_now, hourone_now, mindec_now, minone_now} ==
            {hourdec_bud, hourone_bud, mindec_bud, minone_bud});
      mr = mt && !m_prev_match;
      sr = snooze && !m_prev_snz;
      if (!bud_en) m_mode = M_IDLE;
      else if (m_mode == M_IDLE) m_mode = M_ARMED;
      else if (m_mode == M_ARMED) begin
        if (mr) begin m_mode = M_RING; m_secs = 0; m_ring_ticks = 0; m_snz = 0; end
      end else if (m_mode == M_RING) begin
        if (off_bud) m_mode = M_ARMED;
        else if (sr && m_snz < MAX_SNOOZE) begin m_mode = M_SNOOZE; m_secs = 0; m_snz++; end
        else if (tick_sec) begin
          m_secs++; m_ring_ticks++;
          if (m_secs == RING_SEC) m_mode = M_ARMED;
        end
      end else begin
        if (off_bud) m_mode = M_ARMED;
        else if (tick_sec) begin
          m_secs++;
          if (m_secs == SNOOZE_SEC) begin m_mode = M_RING; m_secs = 0; m_ring_ticks = 0; end
        end
      end
      m_prev_match = mt;
      m_prev_snz   = snooze;
    end
    exp_w = {2'(m_mode),
             (m_mode == M_RING) && ((m_ring_ticks % (BEEP_ON + BEEP_OFF)) < BEEP_ON),
             m_mode == M_RING, m_mode == M_SNOOZE, 3'(m_snz)};
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_tick();
    tick_sec = 1'b1; cyc(); tick_sec = 1'b0;
  endtask

  task automatic set_now(input logic [3:0] hd, input logic [3:0] ho,
                         input logic [3:0] md, input logic [3:0] mo);
    hourdec_now = hd; hourone_now = ho; mindec_now = md; minone_now = mo;
  endtask

  task automatic start_ring();
    set_now(4'd0, 4'd7, 4'd3, 4'd1); cyc();
    set_now(4'd0, 4'd7, 4'd3, 4'd0); cyc();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) cyc();
    checks++;
    if (obs_w !== 8'h00) begin
      errors++; $display("FAIL reset_outputs: got %b want %b", obs_w, 8'h00);
    end
    rstn = 1'b1;
    cyc();
    checks++;
    if (obs_w !== exp_w || state_dbg !== 2'd0) begin
      errors++; $display("FAIL reset_idle: got %b want %b", obs_w, exp_w);
    end
  endtask

  task automatic test_ring_cadence();
    logic [0:0] exp_q[$];
    logic [0:0] e;
    set_now(4'd0, 4'd7, 4'd2, 4'd9);
    bud_en = 1'b1;
    cyc(); cyc();
    checks++;
    if (state_dbg !== 2'd1 || ringing !== 1'b0) begin
      errors++; $display("FAIL armed: got state %0d ringing %b want 1 0", state_dbg, ringing);
    end
    for (int i = 0; i < RING_SEC; i++) exp_q.push_back(1'((i % (BEEP_ON + BEEP_OFF)) < BEEP_ON));
    set_now(4'd0, 4'd7, 4'd3, 4'd0);
    cyc();
    for (int i = 0; i < RING_SEC; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (aud_en !== e || ringing !== 1'b1) begin
        errors++; $display("FAIL cadence_%0d: got aud %b ringing %b want %b 1", i, aud_en, ringing, e);
      end
      repeat ($urandom_range(0, 2)) begin
        cyc();
        checks++;
        if (obs_w !== exp_w) begin
          errors++; $display("FAIL cadence_hold: got %b want %b", obs_w, exp_w);
        end
      end
      pulse_tick();
    end
    checks++;
    if ({ringing, aud_en, state_dbg} !== {1'b0, 1'b0, 2'd1}) begin
      errors++; $display("FAIL auto_off: got %b want %b", {ringing, aud_en, state_dbg}, 4'b0001);
    end
    repeat (5) begin
      pulse_tick(); cyc();
      checks++;
      if (ringing !== 1'b0 || obs_w !== exp_w) begin
        errors++; $display("FAIL no_rering: got %b want %b", obs_w, exp_w);
      end
    end
  endtask

  task automatic test_off_bud();
    start_ring();
    cyc();
    off_bud = 1'b1; cyc(); off_bud = 1'b0;
    checks++;
    if (aud_en !== 1'b0 || ringing !== 1'b0 || obs_w !== exp_w) begin
      errors++; $display("FAIL off_bud: got %b want %b", obs_w, exp_w);
    end
    start_ring();
    checks++;
    if (ringing !== 1'b1 || aud_en !== 1'b1) begin
      errors++; $display("FAIL rering_next_match: got ringing %b aud %b want 1 1", ringing, aud_en);
    end
  endtask

  task automatic test_snooze();
    snooze = 1'b1;
    repeat (10) cyc();
    snooze = 1'b0;
    checks++;
    if (snoozing !== 1'b1 || snooze_cnt !== 3'd1 || obs_w !== exp_w) begin
      errors++; $display("FAIL snooze_once: got %b want snoozing=1 cnt=1 model %b", obs_w, exp_w);
    end
    repeat (SNOOZE_SEC - 1) pulse_tick();
    checks++;
    if (snoozing !== 1'b1 || aud_en !== 1'b0) begin
      errors++; $display("FAIL snooze_hold: got snoozing %b aud %b want 1 0", snoozing, aud_en);
    end
    pulse_tick();
    checks++;
    if (ringing !== 1'b1 || aud_en !== 1'b1 || snooze_cnt !== 3'd1) begin
      errors++; $display("FAIL snooze_rering: got %b want ringing=1 aud=1 cnt=1", obs_w);
    end
    snooze = 1'b1; cyc(); snooze = 1'b0; cyc();
    checks++;
    if (snoozing !== 1'b1 || snooze_cnt !== 3'd2) begin
      errors++; $display("FAIL snooze_second: got snoozing %b cnt %0d want 1 2", snoozing, snooze_cnt);
    end
    repeat (SNOOZE_SEC) pulse_tick();
    snooze = 1'b1; cyc(); snooze = 1'b0; cyc();
    checks++;
    if (ringing !== 1'b1 || snoozing !== 1'b0 || snooze_cnt !== 3'd2 || obs_w !== exp_w) begin
      errors++; $display("FAIL snooze_saturate: got %b want %b", obs_w, exp_w);
    end
    off_bud = 1'b1; cyc(); off_bud = 1'b0;
  endtask

  task automatic test_arm_during_match();
    bud_en = 1'b0; cyc();
    checks++;
    if (state_dbg !== 2'd0 || obs_w !== exp_w) begin
      errors++; $display("FAIL bud_en_low_idle: got %b want %b", obs_w, exp_w);
    end
    bud_en = 1'b1;
    repeat (3) begin
      pulse_tick();
      checks++;
      if (ringing !== 1'b0 || obs_w !== exp_w) begin
        errors++; $display("FAIL arm_in_match: got %b want %b", obs_w, exp_w);
      end
    end
    start_ring();
    bud_en = 1'b0; cyc();
    checks++;
    if (state_dbg !== 2'd0 || aud_en !== 1'b0 || ringing !== 1'b0) begin
      errors++; $display("FAIL bud_en_drop: got %b want state 0 aud 0 ringing 0", obs_w);
    end
    bud_en = 1'b1; cyc();
  endtask

  task automatic test_back_to_back();
    start_ring();
    snooze = 1'b1; cyc(); snooze = 1'b0;
    repeat (SNOOZE_SEC) pulse_tick();
    off_bud = 1'b1; snooze = 1'b1; cyc(); off_bud = 1'b0; snooze = 1'b0; cyc();
    checks++;
    if (state_dbg !== 2'd1 || snooze_cnt !== 3'd1 || obs_w !== exp_w) begin
      errors++; $display("FAIL off_and_snooze: got %b want state 1 cnt 1 model %b", obs_w, exp_w);
    end
    start_ring();
    repeat (RING_SEC - 1) pulse_tick();
    tick_sec = 1'b1; snooze = 1'b1; cyc(); tick_sec = 1'b0; snooze = 1'b0;
    checks++;
    if (snoozing !== 1'b1 || snooze_cnt !== 3'd1 || obs_w !== exp_w) begin
      errors++; $display("FAIL snooze_beats_timeout: got %b want %b", obs_w, exp_w);
    end
    repeat (SNOOZE_SEC) pulse_tick();
    repeat (RING_SEC - 1) pulse_tick();
    tick_sec = 1'b1; off_bud = 1'b1; cyc(); tick_sec = 1'b0; off_bud = 1'b0;
    checks++;
    if (state_dbg !== 2'd1 || ringing !== 1'b0 || obs_w !== exp_w) begin
      errors++; $display("FAIL off_with_timeout: got %b want %b", obs_w, exp_w);
    end
  endtask

  task automatic test_async_reset();
    start_ring();
    snooze = 1'b1; cyc(); snooze = 1'b0;
    repeat (SNOOZE_SEC) pulse_tick();
    @(posedge clk); #3;
    rstn = 1'b0;
    #1;
    checks++;
    if (aud_en !== 1'b0 || ringing !== 1'b0 || snooze_cnt !== 3'd0 || state_dbg !== 2'd0) begin
      errors++; $display("FAIL async_reset: got %b want 00000000", obs_w);
    end
    @(negedge clk);
    bud_en = 1'b0;
    rstn = 1'b1;
    checks++;
    if (state_dbg !== 2'd0) begin
      errors++; $display("FAIL reset_release: got state %0d want 0", state_dbg);
    end
    repeat (3) cyc();
    checks++;
    if (state_dbg !== 2'd0 || obs_w !== exp_w) begin
      errors++; $display("FAIL idle_wait_bud_en: got %b want %b", obs_w, exp_w);
    end
    bud_en = 1'b1; cyc();
    checks++;
    if (state_dbg !== 2'd1) begin
      errors++; $display("FAIL armed_after_reset: got state %0d want 1", state_dbg);
    end
  endtask

  task automatic test_random();
    int sel;
    for (int i = 0; i < 3000; i++) begin
      bud_en   = ($urandom_range(0, 99) < 97);
      off_bud  = ($urandom_range(0, 99) < 3);
      tick_sec = ($urandom_range(0, 99) < 30);
      if ($urandom_range(0, 7) == 0) snooze = ~snooze;
      if ($urandom_range(0, 19) == 0) begin
        sel = $urandom_range(0, 2);
        if (sel == 0) set_now(4'd0, 4'd7, 4'd3, 4'd0);
        else if (sel == 1) set_now(4'd0, 4'd7, 4'd3, 4'd1);
        else set_now(4'd1, 4'd2, 4'd5, 4'd9);
      end
      cyc();
      checks++;
      if (obs_w !== exp_w) begin
        errors++; $display("FAIL random_%0d: got %b want %b", i, obs_w, exp_w);
      end
    end
    tick_sec = 1'b0; off_bud = 1'b0; snooze = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    test_reset();
    test_ring_cadence();
    test_off_bud();
    test_snooze();
    test_arm_during_match();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
